// File: rtl/reg_write_arbiter_if.sv
// Writeback bus between the pipeline (A), the multicycle unit (B) and the register file.
// The arbiter connects through the slave modport; the requesters/register file side through master.
interface reg_write_arbiter_if;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  logic              AValid;
  logic [REG_W-1:0]  ARegister;
  logic [DATA_W-1:0] AData;
  logic              AReady;
  logic              BValid;
  logic [REG_W-1:0]  BRegister;
  logic [DATA_W-1:0] BData;
  logic              BReady;
  logic              RegWrite;
  logic [REG_W-1:0]  WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic              Collision;

  modport master (
    output AValid, ARegister, AData, BValid, BRegister, BData,
    input  AReady, BReady, RegWrite, WriteRegister, WriteData, Collision
  );

  modport slave (
    input  AValid, ARegister, AData, BValid, BRegister, BData,
    output AReady, BReady, RegWrite, WriteRegister, WriteData, Collision
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Single-port register-file write arbiter: pipeline (A) has priority, the multicycle
// unit (B) is buffered in a 2-entry FIFO and forced through after MAX_WAIT lost cycles.
module reg_write_arbiter #(
  parameter int unsigned MAX_WAIT = 2
) (
  input logic               clk,
  input logic               rst,
  reg_write_arbiter_if.slave bus
);
  localparam int unsigned REG_W   = 5;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ENTRY_W = REG_W + DATA_W;
  localparam int unsigned DEPTH   = 2;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned STARVE_W = 3;

  // FIFO entry 0 is always the head; a pop shifts entry 1 down
  logic [ENTRY_W-1:0]  fifoMem     [DEPTH];
  logic [ENTRY_W-1:0]  fifoMemNext [DEPTH];
  logic [CNT_W-1:0]    count, countNext;
  logic [STARVE_W-1:0] starve, starveNext;

  logic              regWriteNext;
  logic [REG_W-1:0]  writeRegisterNext;
  logic [DATA_W-1:0] writeDataNext;
  logic              collisionNext;

  logic              headValid, forced, grantA, grantB, push;
  logic [REG_W-1:0]  headReg;
  logic [DATA_W-1:0] headData;

  assign headReg  = fifoMem[0][ENTRY_W-1:DATA_W];
  assign headData = fifoMem[0][DATA_W-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      count             <= '0;
      starve            <= '0;
      bus.RegWrite      <= 1'b0;
      bus.WriteRegister <= '0;
      bus.WriteData     <= '0;
      bus.Collision     <= 1'b0;
    end else begin
      count             <= countNext;
      starve            <= starveNext;
      bus.RegWrite      <= regWriteNext;
      bus.WriteRegister <= writeRegisterNext;
      bus.WriteData     <= writeDataNext;
      bus.Collision     <= collisionNext;
    end
    fifoMem <= fifoMemNext;
  end

  // Handshakes and grant decision; ready signals depend on registered state only
  always_comb begin
    headValid  = (count != CNT_W'(0));
    forced     = headValid && (starve == STARVE_W'(MAX_WAIT));
    bus.AReady = !rst && !forced;
    bus.BReady = !rst && (count < CNT_W'(DEPTH));
    grantA     = bus.AValid && bus.AReady;
    grantB     = !rst && headValid && !grantA;
    push       = bus.BValid && bus.BReady;
  end

  // Next-state: write port, starvation counter, FIFO push/pop
  always_comb begin
    fifoMemNext       = fifoMem;
    countNext         = count;
    starveNext        = starve;
    regWriteNext      = 1'b0;
    writeRegisterNext = bus.WriteRegister;
    writeDataNext     = bus.WriteData;
    collisionNext     = bus.AValid && headValid && (bus.ARegister == headReg)
                        && (bus.ARegister != REG_W'(0));

    if (grantA) begin
      regWriteNext      = (bus.ARegister != REG_W'(0));
      writeRegisterNext = bus.ARegister;
      writeDataNext     = bus.AData;
    end else if (grantB) begin
      regWriteNext      = (headReg != REG_W'(0));
      writeRegisterNext = headReg;
      writeDataNext     = headData;
    end

    if (!headValid || grantB) begin
      starveNext = '0;
    end else if (grantA && (starve != STARVE_W'(MAX_WAIT))) begin
      starveNext = STARVE_W'(starve + STARVE_W'(1));
    end

    if (grantB) begin
      fifoMemNext[0] = fifoMem[1];
      countNext      = CNT_W'(count - CNT_W'(1));
    end
    // Push lands behind whatever remains after a same-edge pop
    if (push) begin
      fifoMemNext[countNext[0]] = {bus.BRegister, bus.BData};
      countNext                 = CNT_W'(countNext + CNT_W'(1));
    end
  end
endmodule
